// File: rtl/phase_sequencer.sv
// Multi-cycle phase generator for the multi-cycle CPU: one-hot phase vector, run/stall
// handling, illegal-opcode trapping and cycle/instruction counters.
module phase_sequencer #(
    parameter int CNT_W           = 32,
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             stall,
    input  logic [5:0]       op,
    input  logic [5:0]       irfunc,
    output logic [4:0]       p,
    output logic             busy,
    output logic             instr_done,
    output logic             illegal,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
);

    // One-hot encoding: the low five state bits are the phase vector itself.
    typedef enum logic [5:0] {
        S_IDLE = 6'b000000,
        S_P0   = 6'b000001,
        S_P1   = 6'b000010,
        S_P2   = 6'b000100,
        S_P3   = 6'b001000,
        S_P4   = 6'b010000,
        S_HALT = 6'b100000
    } state_t;

    typedef enum logic [1:0] {
        PATH_FULL,   // P0 P1 P2 P3 P4
        PATH_STORE,  // P0 P1 P2 P3
        PATH_ALU,    // P0 P1 P2 P4
        PATH_BRANCH  // P0 P1 P2
    } path_t;

    state_t state;
    path_t  path;
    path_t  dec_path;
    logic   dec_legal;
    logic   final_phase;
    state_t start_state;

    assign p           = state[4:0];
    assign busy        = |state[4:0];
    assign start_state = run ? S_P0 : S_IDLE;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        dec_legal = 1'b1;
        dec_path  = PATH_FULL;
        case (op)
            6'b100011, 6'b000010, 6'b000011: dec_path = PATH_FULL;
            6'b101011:                       dec_path = PATH_STORE;
            6'b000100, 6'b000101:            dec_path = PATH_BRANCH;
            6'b000000: begin
                case (irfunc)
                    6'b100000, 6'b101010: dec_path = PATH_ALU;
                    6'b001000, 6'b001001: dec_path = PATH_FULL;
                    default:              dec_legal = 1'b0;
                endcase
            end
            default: dec_legal = 1'b0;
        endcase
    end

    // The path is latched when P1 retires, so op changes in P3/P4 cannot alter it.
    always_comb begin
        final_phase = 1'b0;
        case (state)
            S_P2:    final_phase = (path == PATH_BRANCH);
            S_P3:    final_phase = (path == PATH_STORE);
            S_P4:    final_phase = 1'b1;
            default: final_phase = 1'b0;
        endcase
    end

    assign instr_done = final_phase && !stall;

    // NOTE: all state here is sequential, so only non-blocking assignments are used.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= S_IDLE;
            path      <= PATH_FULL;
            illegal   <= 1'b0;
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else begin
            if (busy) begin
                cycle_cnt <= cycle_cnt + CNT_W'(1);
            end
            if (instr_done) begin
                instr_cnt <= instr_cnt + CNT_W'(1);
            end
            // A stall freezes any P state; IDLE and HALT ignore it.
            if (!(busy && stall)) begin
                case (state)
                    S_IDLE: begin
                        if (run) begin
                            state <= S_P0;
                        end
                    end
                    S_P0: state <= S_P1;
                    S_P1: begin
                        if (dec_legal) begin
                            path  <= dec_path;
                            state <= S_P2;
                        end else begin
                            illegal <= 1'b1;
                            state   <= HALT_ON_ILLEGAL ? S_HALT : start_state;
                        end
                    end
                    S_P2: begin
                        if (final_phase) begin
                            state <= start_state;
                        end else if (path == PATH_ALU) begin
                            state <= S_P4;
                        end else begin
                            state <= S_P3;
                        end
                    end
                    S_P3: state <= final_phase ? start_state : S_P4;
                    S_P4: state <= start_state;
                    S_HALT: state <= S_HALT;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
